// File: rtl/jogo_sequencia_param_if.sv
// Player/display signal bundle for the sequence-memory game controller.
// The bench or game top drives through master; the controller uses slave.
interface jogo_sequencia_param_if #(
    parameter int NBOTOES = 4,
    parameter int DEPTH   = 16,
    parameter int VIDAS   = 3
);
    localparam int AW = $clog2(DEPTH);
    localparam int VW = $clog2(VIDAS + 1);

    logic               iniciar;
    logic [1:0]         modo;
    logic [NBOTOES-1:0] botoes;
    logic               carga;
    logic [AW-1:0]      carga_end;
    logic [NBOTOES-1:0] carga_dado;
    logic [NBOTOES-1:0] leds;
    logic [AW-1:0]      rodada;
    logic [VW-1:0]      vidas_restantes;
    logic               acertou;
    logic               errou;
    logic               timeout_out;
    logic               pronto;
    logic [3:0]         db_estado;

    modport master (
        output iniciar, modo, botoes, carga, carga_end, carga_dado,
        input  leds, rodada, vidas_restantes, acertou, errou, timeout_out, pronto, db_estado
    );

    modport slave (
        input  iniciar, modo, botoes, carga, carga_end, carga_dado,
        output leds, rodada, vidas_restantes, acertou, errou, timeout_out, pronto, db_estado
    );
endinterface

// File: rtl/jogo_sequencia_param.sv
// Sequence-memory game: play FSM, address/limit/timer counters, sequence RAM
// and lives counter in one block.
module jogo_sequencia_param #(
    parameter int NBOTOES = 4,
    parameter int DEPTH   = 16,
    parameter int T_LED   = 500,
    parameter int T_RESP  = 5000,
    parameter int VIDAS   = 3
) (
    input logic                  clock,
    input logic                  reset,
    jogo_sequencia_param_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int VW   = $clog2(VIDAS + 1);
    localparam int TMAX = (T_LED > T_RESP) ? T_LED : T_RESP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [3:0] {
        S_INICIAL        = 4'd0,
        S_PREPARACAO     = 4'd1,
        S_CARREGA        = 4'd2,
        S_MOSTRA         = 4'd3,
        S_APAGADO        = 4'd4,
        S_PROXIMO_LED    = 4'd5,
        S_ESPERA         = 4'd6,
        S_REGISTRA       = 4'd7,
        S_COMPARA        = 4'd8,
        S_PROXIMO        = 4'd9,
        S_ADICIONA       = 4'd10,
        S_PROXIMA_RODADA = 4'd11,
        S_PERDE_VIDA     = 4'd12,
        S_FINAL_ACERTO   = 4'd13,
        S_FINAL_ERRO     = 4'd14,
        S_FINAL_TIMEOUT  = 4'd15
    } estado_t;

    estado_t            r_state, w_state_next;
    logic [AW-1:0]      r_addr, w_addr_next;
    logic [AW-1:0]      r_limite, w_limite_next;
    logic [VW-1:0]      r_vidas, w_vidas_next;
    logic [TW-1:0]      r_timer, w_timer_next;
    logic [1:0]         r_modo, w_modo_next;
    logic [NBOTOES-1:0] r_jogada, w_jogada_next;
    logic               r_botoes_any;
    logic [NBOTOES-1:0] r_mem [DEPTH];

    logic               w_jogada;
    logic               w_final;
    logic               w_onehot;
    logic               w_mismatch;
    logic               w_we;
    logic [AW-1:0]      w_waddr;
    logic [NBOTOES-1:0] w_wdata;
    logic [NBOTOES-1:0] w_mem_rd;

    assign w_jogada   = (|bus.botoes) && !r_botoes_any;
    assign w_final    = (r_state == S_FINAL_ACERTO) || (r_state == S_FINAL_ERRO) ||
                        (r_state == S_FINAL_TIMEOUT);
    assign w_mem_rd   = r_mem[r_addr];
    assign w_onehot   = (r_jogada != '0) && ((r_jogada & (r_jogada - 1'b1)) == '0);
    assign w_mismatch = !w_onehot || (r_jogada != w_mem_rd);

    // Loading is confined to idle/final states, so it never races the display read.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = bus.carga_end;
        w_wdata = bus.carga_dado;
        if (r_state == S_ADICIONA) begin
            w_we    = w_jogada;
            w_waddr = r_limite + AW'(1);
            w_wdata = bus.botoes;
        end else if (bus.carga && (r_state == S_INICIAL || w_final)) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_INICIAL;
            r_addr       <= '0;
            r_limite     <= '0;
            r_vidas      <= VW'(VIDAS);
            r_timer      <= '0;
            r_modo       <= '0;
            r_jogada     <= '0;
            r_botoes_any <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_limite     <= w_limite_next;
            r_vidas      <= w_vidas_next;
            r_timer      <= w_timer_next;
            r_modo       <= w_modo_next;
            r_jogada     <= w_jogada_next;
            r_botoes_any <= |bus.botoes;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_addr_next   = r_addr;
        w_limite_next = r_limite;
        w_vidas_next  = r_vidas;
        w_timer_next  = r_timer;
        w_modo_next   = r_modo;
        w_jogada_next = r_jogada;
        unique case (r_state)
            S_INICIAL, S_FINAL_ACERTO, S_FINAL_ERRO, S_FINAL_TIMEOUT: begin
                if (bus.iniciar) w_state_next = S_PREPARACAO;
            end
            S_PREPARACAO: begin
                w_modo_next   = bus.modo;
                w_addr_next   = '0;
                w_limite_next = '0;
                w_vidas_next  = VW'(VIDAS);
                w_timer_next  = '0;
                w_state_next  = S_CARREGA;
            end
            S_CARREGA: begin
                w_timer_next = '0;
                w_state_next = S_MOSTRA;
            end
            S_MOSTRA: begin
                if (r_timer == TW'(T_LED - 1)) begin
                    w_timer_next = '0;
                    w_state_next = S_APAGADO;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_APAGADO: begin
                if (r_timer == TW'(T_LED - 1)) begin
                    w_timer_next = '0;
                    if (r_addr == r_limite) begin
                        w_addr_next  = '0;
                        w_state_next = S_ESPERA;
                    end else begin
                        w_state_next = S_PROXIMO_LED;
                    end
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_PROXIMO_LED: begin
                w_addr_next  = r_addr + AW'(1);
                w_state_next = S_CARREGA;
            end
            S_ESPERA: begin
                // A press on the last allowed cycle beats the timeout; the timer
                // saturates so an untimed wait can last forever.
                if (w_jogada) begin
                    w_state_next = S_REGISTRA;
                end else if (r_timer == TW'(T_RESP - 1)) begin
                    if (r_modo[0]) w_state_next = S_FINAL_TIMEOUT;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            S_REGISTRA: begin
                w_jogada_next = bus.botoes;
                w_state_next  = S_COMPARA;
            end
            S_COMPARA: begin
                if (w_mismatch)                        w_state_next = S_PERDE_VIDA;
                else if (r_addr != r_limite)           w_state_next = S_PROXIMO;
                else if (r_limite == AW'(DEPTH - 1))   w_state_next = S_FINAL_ACERTO;
                else if (r_modo[1])                    w_state_next = S_ADICIONA;
                else                                   w_state_next = S_PROXIMA_RODADA;
            end
            S_PROXIMO: begin
                w_addr_next  = r_addr + AW'(1);
                w_timer_next = '0;
                w_state_next = S_ESPERA;
            end
            S_ADICIONA: begin
                if (w_jogada) w_state_next = S_PROXIMA_RODADA;
            end
            S_PROXIMA_RODADA: begin
                w_limite_next = r_limite + AW'(1);
                w_addr_next   = '0;
                w_state_next  = S_CARREGA;
            end
            S_PERDE_VIDA: begin
                w_vidas_next = r_vidas - VW'(1);
                if (r_vidas == VW'(1)) begin
                    w_state_next = S_FINAL_ERRO;
                end else begin
                    w_addr_next  = '0;
                    w_state_next = S_CARREGA;
                end
            end
            default: w_state_next = S_INICIAL;
        endcase
    end

    assign bus.leds            = (r_state == S_MOSTRA) ? w_mem_rd : '0;
    assign bus.rodada          = r_limite;
    assign bus.vidas_restantes = r_vidas;
    assign bus.acertou         = (r_state == S_FINAL_ACERTO);
    assign bus.errou           = (r_state == S_FINAL_ERRO);
    assign bus.timeout_out     = (r_state == S_FINAL_TIMEOUT);
    assign bus.pronto          = w_final;
    assign bus.db_estado       = r_state;
endmodule

// File: tb/tb_jogo_sequencia_param.sv
// Scoreboard bench: stimulus queues expected LED pulses, lives changes and
// game endings; independent monitors pop and compare as the DUT shows them.
module tb_jogo_sequencia_param;
    localparam int NB = 4;
    localparam int DP = 4;
    localparam int TL = 4;
    localparam int TR = 20;
    localparam int VD = 3;

    typedef struct packed {
        logic       a;
        logic       e;
        logic       t;
        logic [1:0] vid;
        logic [1:0] rod;
    } fin_t;

    typedef struct packed {
        logic [1:0] vid;
        logic [1:0] rod;
    } vr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [NB-1:0] q_led [$];
    fin_t          q_fin [$];
    vr_t           q_vr  [$];

    jogo_sequencia_param_if #(.NBOTOES(NB), .DEPTH(DP), .VIDAS(VD)) bus ();

    jogo_sequencia_param #(
        .NBOTOES(NB), .DEPTH(DP), .T_LED(TL), .T_RESP(TR), .VIDAS(VD)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // LED monitor: value and on-length of each display pulse
    initial begin : mon_led
        logic          in_pulse;
        logic [NB-1:0] cur;
        int            len;
        logic [NB-1:0] e;
        in_pulse = 1'b0; cur = '0; len = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_pulse = 1'b0;
            end else if (!in_pulse) begin
                if (bus.leds != '0) begin in_pulse = 1'b1; cur = bus.leds; len = 1; end
            end else if (bus.leds == cur) begin
                len++;
            end else begin
                if (q_led.size() == 0) check("led_extra", 32'(cur), 32'd0);
                else begin
                    e = q_led.pop_front();
                    check("led_val", 32'(cur), 32'(e));
                    check("led_len", len, TL);
                end
                in_pulse = (bus.leds != '0);
                cur = bus.leds; len = 1;
            end
        end
    end

    initial begin : mon_vidas
        logic [1:0] prev;
        vr_t        e;
        prev = 2'(VD);
        forever begin
            @(negedge clock);
            if (!reset && bus.vidas_restantes != prev) begin
                if (q_vr.size() == 0) check("vidas_extra", 32'(bus.vidas_restantes), 32'(prev));
                else begin
                    e = q_vr.pop_front();
                    check("vidas_val", 32'(bus.vidas_restantes), 32'(e.vid));
                    check("vidas_rodada", 32'(bus.rodada), 32'(e.rod));
                end
            end
            prev = bus.vidas_restantes;
        end
    end

    initial begin : mon_final
        logic prev;
        fin_t e;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && bus.pronto && !prev) begin
                if (q_fin.size() == 0) check("final_extra", 32'(bus.db_estado), 32'd0);
                else begin
                    e = q_fin.pop_front();
                    check("fin_acertou", 32'(bus.acertou), 32'(e.a));
                    check("fin_errou", 32'(bus.errou), 32'(e.e));
                    check("fin_timeout", 32'(bus.timeout_out), 32'(e.t));
                    check("fin_vidas", 32'(bus.vidas_restantes), 32'(e.vid));
                    check("fin_rodada", 32'(bus.rodada), 32'(e.rod));
                end
            end
            prev = reset ? 1'b0 : bus.pronto;
        end
    end

    task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
        int k = 0;
        while (bus.db_estado !== s && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (bus.db_estado !== s) check(nm, 32'(bus.db_estado), 32'(s));
    endtask

    task automatic load(input logic [1:0] a, input logic [NB-1:0] d);
        bus.carga_end = a; bus.carga_dado = d; bus.carga = 1'b1;
        @(posedge clock); #1;
        bus.carga = 1'b0;
    endtask

    task automatic start(input logic [1:0] m);
        bus.modo = m; bus.iniciar = 1'b1;
        @(posedge clock); #1;
        bus.iniciar = 1'b0;
    endtask

    task automatic press(input logic [3:0] st, input logic [NB-1:0] v);
        wait_state(st, 300, "press_wait");
        bus.botoes = v;
        repeat (2) @(posedge clock);
        #1 bus.botoes = '0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic push_leds(input int n, input logic [4*NB-1:0] seq);
        for (int i = 0; i < n; i++) q_led.push_back(seq[i*NB +: NB]);
    endtask

    task automatic play(input int n, input logic [4*NB-1:0] seq);
        for (int i = 0; i < n; i++) press(4'd6, seq[i*NB +: NB]);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [4*NB-1:0] s1;
        logic [4*NB-1:0] s2;
        s1 = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        s2 = {4'b1000, 4'b0010, 4'b0100, 4'b0001};
        bus.iniciar = 1'b0; bus.modo = 2'b00; bus.botoes = '0;
        bus.carga = 1'b0; bus.carga_end = '0; bus.carga_dado = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_estado", 32'(bus.db_estado), 32'd0);
        check("rst_leds", 32'(bus.leds), 32'd0);
        check("rst_rodada", 32'(bus.rodada), 32'd0);
        check("rst_vidas", 32'(bus.vidas_restantes), 32'(VD));
        check("rst_flags", {bus.acertou, bus.errou, bus.timeout_out, bus.pronto}, 32'd0);

        // 1: fixed mode, four correct rounds
        for (int i = 0; i < 4; i++) load(2'(i), s1[i*NB +: NB]);
        start(2'b00);
        for (int r = 1; r <= 4; r++) begin
            push_leds(r, s1);
            if (r == 4) q_fin.push_back('{a:1'b1, e:1'b0, t:1'b0, vid:2'd3, rod:2'd3});
            play(r, s1);
        end
        wait_state(4'd13, 50, "t1_final");

        // 2: errors in round 2 replay it, third error ends the game
        start(2'b00);
        push_leds(1, s1); play(1, s1);
        push_leds(2, s1);
        press(4'd6, 4'b0001);
        q_vr.push_back('{vid:2'd2, rod:2'd1});
        push_leds(2, s1);
        press(4'd6, 4'b0100);
        q_vr.push_back('{vid:2'd1, rod:2'd1});
        push_leds(2, s1);
        press(4'd6, 4'b1000);
        q_vr.push_back('{vid:2'd0, rod:2'd1});
        q_fin.push_back('{a:1'b0, e:1'b1, t:1'b0, vid:2'd0, rod:2'd1});
        press(4'd6, 4'b0010);
        wait_state(4'd14, 50, "t2_final");

        // 3: timeout after exactly T_RESP cycles in espera; none with modo=00
        q_vr.push_back('{vid:2'd3, rod:2'd0});
        start(2'b01);
        push_leds(1, s1);
        q_fin.push_back('{a:1'b0, e:1'b0, t:1'b1, vid:2'd3, rod:2'd0});
        wait_state(4'd6, 300, "t3_espera");
        repeat (TR - 1) @(negedge clock);
        check("t3_last_espera", 32'(bus.db_estado), 32'd6);
        check("t3_no_timeout_yet", 32'(bus.timeout_out), 32'd0);
        @(negedge clock);
        check("t3_timeout", 32'(bus.timeout_out), 32'd1);
        start(2'b00);
        push_leds(1, s1);
        wait_state(4'd6, 300, "t3b_espera");
        repeat (3 * TR) @(negedge clock);
        check("t3b_still_espera", 32'(bus.db_estado), 32'd6);
        check("t3b_no_timeout", 32'(bus.timeout_out), 32'd0);
        @(posedge clock); #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // 4: expansion mode builds the sequence 0001,0100,0010,1000
        start(2'b10);
        push_leds(1, s2); play(1, s2);
        press(4'd10, 4'b0100);
        check("t4_rodada", 32'(bus.rodada), 32'd1);
        push_leds(2, s2); play(2, s2);
        press(4'd10, 4'b0010);
        push_leds(3, s2); play(3, s2);
        press(4'd10, 4'b1000);
        push_leds(4, s2);
        q_fin.push_back('{a:1'b1, e:1'b0, t:1'b0, vid:2'd3, rod:2'd3});
        play(4, s2);
        wait_state(4'd13, 50, "t4_final");

        // 5a: a non-one-hot jogada never matches, even against an equal entry
        load(2'd0, 4'b0011);
        start(2'b01);
        push_leds(1, {12'h0, 4'b0011});
        press(4'd6, 4'b0011);
        q_vr.push_back('{vid:2'd2, rod:2'd0});
        push_leds(1, {12'h0, 4'b0011});
        press(4'd6, 4'b0011);
        q_vr.push_back('{vid:2'd1, rod:2'd0});
        push_leds(1, {12'h0, 4'b0011});
        q_vr.push_back('{vid:2'd0, rod:2'd0});
        q_fin.push_back('{a:1'b0, e:1'b1, t:1'b0, vid:2'd0, rod:2'd0});
        press(4'd6, 4'b0011);
        wait_state(4'd14, 50, "t5a_final");

        // 5b: a jogada on the timeout cycle is registered
        load(2'd0, 4'b0001);
        q_vr.push_back('{vid:2'd3, rod:2'd0});
        start(2'b01);
        push_leds(1, s2);
        wait_state(4'd6, 300, "t5b_espera");
        repeat (TR - 1) @(negedge clock);
        bus.botoes = 4'b0001;
        @(negedge clock);
        check("t5b_registra", 32'(bus.db_estado), 32'd7);
        @(posedge clock); #1 bus.botoes = '0;
        push_leds(2, s2);
        q_fin.push_back('{a:1'b0, e:1'b0, t:1'b1, vid:2'd3, rod:2'd1});
        wait_state(4'd15, 300, "t5b_final");

        // 6: reset during display, then the kept RAM replays
        start(2'b00);
        wait_state(4'd3, 50, "t6_mostra");
        @(posedge clock); #1 reset = 1'b1;
        #1;
        check("t6_rst_leds", 32'(bus.leds), 32'd0);
        check("t6_rst_estado", 32'(bus.db_estado), 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        start(2'b00);
        for (int r = 1; r <= 4; r++) begin
            push_leds(r, s2);
            if (r == 4) q_fin.push_back('{a:1'b1, e:1'b0, t:1'b0, vid:2'd3, rod:2'd3});
            play(r, s2);
        end
        wait_state(4'd13, 50, "t6_final");

        repeat (5) @(posedge clock);
        check("left_led", q_led.size(), 32'd0);
        check("left_vidas", q_vr.size(), 32'd0);
        check("left_final", q_fin.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
